// File: rtl/program_loader_pkg.sv
// Shared types and constants for the RISC15 boot-time program loader.
package loader_pkg;
    localparam int LD_MAX_WORDS = 32;
    localparam int LD_BYTE_W    = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory load port between the loader and its neighbours.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic                 in_valid;
    logic [LD_BYTE_W-1:0] in_data;
    logic                 in_ready;
    logic                 ld_we;
    logic [ADDR_W-1:0]    ld_addr;
    logic [DATA_W-1:0]    ld_data;
    logic                 core_rst;
    logic                 done;
    logic                 err;

    modport master (
        output in_valid, in_data,
        input  in_ready, ld_we, ld_addr, ld_data, core_rst, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ld_we, ld_addr, ld_data, core_rst, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Assembles a framed byte stream into 16-bit words, writes them to core memory,
// and keeps the core in reset until the frame checksum matches.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input logic             clk,
    input logic             proc_rst,
    input logic             restart,
    program_loader_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [LD_BYTE_W-1:0] MAX_COUNT = LD_BYTE_W'(LD_MAX_WORDS);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [LD_BYTE_W-1:0] hi_q, hi_d;
    logic [LD_BYTE_W-1:0] acc_q, acc_d;
    logic                 ld_we_q, ld_we_d;
    logic [ADDR_W-1:0]    ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0]    ld_data_q, ld_data_d;
    logic                 accept;

    assign accept  = bus.in_valid && bus.in_ready;
    assign cnt_inc = cnt_q + 1'b1;

    // restart outranks any byte offered in the same cycle; that byte is simply lost
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        hi_d      = hi_q;
        acc_d     = acc_q;
        ld_we_d   = 1'b0;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        if (restart) begin
            state_d = IDLE;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_data == '0 || bus.in_data > MAX_COUNT) begin
                        state_d = ERR;
                    end else begin
                        num_d   = bus.in_data[CNT_W-1:0];
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = HI;
                    end
                end
                HI: begin
                    hi_d    = bus.in_data;
                    acc_d   = acc_q ^ bus.in_data;
                    state_d = LO;
                end
                LO: begin
                    acc_d     = acc_q ^ bus.in_data;
                    ld_we_d   = 1'b1;
                    ld_addr_d = cnt_q[ADDR_W-1:0];
                    ld_data_d = {hi_q, bus.in_data};
                    cnt_d     = cnt_inc;
                    state_d   = (cnt_inc == num_q) ? CHK : HI;
                end
                CHK: begin
                    state_d = (bus.in_data == acc_q) ? DONE : ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            hi_q      <= '0;
            acc_q     <= '0;
            ld_we_q   <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            hi_q      <= hi_d;
            acc_q     <= acc_d;
            ld_we_q   <= ld_we_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign bus.in_ready = (state_q != DONE) && (state_q != ERR);
    assign bus.core_rst = (state_q != DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == ERR);
    assign bus.ld_we    = ld_we_q;
    assign bus.ld_addr  = ld_addr_q;
    assign bus.ld_data  = ld_data_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader: each scenario task drives a frame and checks inline.
module tb_program_loader;
    logic clk;
    logic procRst;
    logic restart;
    int   checks   = 0;
    int   failures = 0;
    int   wrTotal  = 0;
    int   cycleCnt = 0;
    logic [4:0]  wrAddr [128];
    logic [15:0] wrData [128];

    program_loader_if #(.ADDR_W(5), .DATA_W(16)) busIf ();

    program_loader #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk      (clk),
        .proc_rst (procRst),
        .restart  (restart),
        .bus      (busIf)
    );

    // free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // record every write strobe seen mid-cycle, in arrival order
    always @(negedge clk) begin
        if (busIf.ld_we === 1'b1) begin
            wrAddr[wrTotal[6:0]] <= busIf.ld_addr;
            wrData[wrTotal[6:0]] <= busIf.ld_data;
            wrTotal <= wrTotal + 1;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        busIf.in_valid = 1'b1;
        busIf.in_data  = b;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        procRst        = 1'b1;
        restart        = 1'b0;
        busIf.in_valid = 1'b0;
        busIf.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busIf.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%0b exp=1", busIf.in_ready); end
        checks++; if (busIf.ld_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_ld_we got=%0b exp=0", busIf.ld_we); end
        checks++; if (busIf.ld_addr !== 5'd0) begin failures++; $display("[TB] FAIL rst_ld_addr got=%0d exp=0", busIf.ld_addr); end
        checks++; if (busIf.ld_data !== 16'h0000) begin failures++; $display("[TB] FAIL rst_ld_data got=%h exp=0000", busIf.ld_data); end
        checks++; if (busIf.core_rst !== 1'b1) begin failures++; $display("[TB] FAIL rst_core_rst got=%0b exp=1", busIf.core_rst); end
        checks++; if (busIf.done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%0b exp=0", busIf.done); end
        checks++; if (busIf.err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got=%0b exp=0", busIf.err); end
        procRst = 1'b0;
        idleCycles(1);
    endtask

    task automatic test_single_word();
        int base;
        base = wrTotal;
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        checks++; if (busIf.ld_we !== 1'b1) begin failures++; $display("[TB] FAIL sw_strobe_latency got=%0b exp=1", busIf.ld_we); end
        sendByte(8'h26);
        checks++; if (wrTotal - base !== 1) begin failures++; $display("[TB] FAIL sw_write_count got=%0d exp=1", wrTotal - base); end
        checks++; if (wrAddr[base[6:0]] !== 5'd0) begin failures++; $display("[TB] FAIL sw_addr got=%0d exp=0", wrAddr[base[6:0]]); end
        checks++; if (wrData[base[6:0]] !== 16'h1234) begin failures++; $display("[TB] FAIL sw_data got=%h exp=1234", wrData[base[6:0]]); end
        checks++; if (busIf.done !== 1'b1) begin failures++; $display("[TB] FAIL sw_done got=%0b exp=1", busIf.done); end
        checks++; if (busIf.core_rst !== 1'b0) begin failures++; $display("[TB] FAIL sw_core_rst got=%0b exp=0", busIf.core_rst); end
        checks++; if (busIf.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL sw_in_ready got=%0b exp=0", busIf.in_ready); end
        checks++; if (busIf.err !== 1'b0) begin failures++; $display("[TB] FAIL sw_err got=%0b exp=0", busIf.err); end
        checks++; if (busIf.ld_data !== 16'h1234) begin failures++; $display("[TB] FAIL sw_data_hold got=%h exp=1234", busIf.ld_data); end
        idleCycles(3);
        checks++; if (busIf.done !== 1'b1) begin failures++; $display("[TB] FAIL sw_done_sticky got=%0b exp=1", busIf.done); end
        pulseRestart();
        checks++; if (busIf.core_rst !== 1'b1) begin failures++; $display("[TB] FAIL sw_restart_core_rst got=%0b exp=1", busIf.core_rst); end
        checks++; if (busIf.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL sw_restart_in_ready got=%0b exp=1", busIf.in_ready); end
        checks++; if (busIf.done !== 1'b0) begin failures++; $display("[TB] FAIL sw_restart_done got=%0b exp=0", busIf.done); end
    endtask

    task automatic test_full_frame();
        int base;
        int startCyc;
        logic [7:0] b;
        base = wrTotal;
        sendByte(8'd32);
        startCyc = cycleCnt;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            sendByte(b);
            sendByte(b);
        end
        checks++; if (busIf.done !== 1'b0) begin failures++; $display("[TB] FAIL ff_done_early got=%0b exp=0", busIf.done); end
        sendByte(8'h00);
        checks++; if (busIf.done !== 1'b1) begin failures++; $display("[TB] FAIL ff_done got=%0b exp=1", busIf.done); end
        checks++; if (cycleCnt - startCyc !== 65) begin failures++; $display("[TB] FAIL ff_done_cycle got=%0d exp=65 edges after first byte", cycleCnt - startCyc); end
        checks++; if (wrTotal - base !== 32) begin failures++; $display("[TB] FAIL ff_write_count got=%0d exp=32", wrTotal - base); end
        for (int i = 0; i < 32; i++) begin
            int k;
            logic [15:0] expData;
            k = base + i;
            expData = 16'(16'h0101 * i);
            checks++; if (wrAddr[k[6:0]] !== 5'(i) || wrData[k[6:0]] !== expData) begin
                failures++; $display("[TB] FAIL ff_word%0d got=%0d:%h exp=%0d:%h", i, wrAddr[k[6:0]], wrData[k[6:0]], i, expData);
            end
        end
        pulseRestart();
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wrTotal;
        sendByte(8'h02);
        sendByte(8'hAA);
        sendByte(8'hAA);
        sendByte(8'h55);
        sendByte(8'h55);
        sendByte(8'h01);
        checks++; if (wrTotal - base !== 2) begin failures++; $display("[TB] FAIL bc_write_count got=%0d exp=2", wrTotal - base); end
        checks++; if (wrAddr[base[6:0]] !== 5'd0 || wrData[base[6:0]] !== 16'hAAAA) begin failures++; $display("[TB] FAIL bc_word0 got=%0d:%h exp=0:aaaa", wrAddr[base[6:0]], wrData[base[6:0]]); end
        base = base + 1;
        checks++; if (wrAddr[base[6:0]] !== 5'd1 || wrData[base[6:0]] !== 16'h5555) begin failures++; $display("[TB] FAIL bc_word1 got=%0d:%h exp=1:5555", wrAddr[base[6:0]], wrData[base[6:0]]); end
        checks++; if (busIf.err !== 1'b1) begin failures++; $display("[TB] FAIL bc_err got=%0b exp=1", busIf.err); end
        checks++; if (busIf.done !== 1'b0) begin failures++; $display("[TB] FAIL bc_done got=%0b exp=0", busIf.done); end
        checks++; if (busIf.core_rst !== 1'b1) begin failures++; $display("[TB] FAIL bc_core_rst got=%0b exp=1", busIf.core_rst); end
        checks++; if (busIf.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bc_in_ready got=%0b exp=0", busIf.in_ready); end
        pulseRestart();
    endtask

    task automatic test_illegal_count();
        int base;
        base = wrTotal;
        sendByte(8'h00);
        checks++; if (busIf.err !== 1'b1) begin failures++; $display("[TB] FAIL ic_zero_err got=%0b exp=1", busIf.err); end
        checks++; if (busIf.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL ic_zero_in_ready got=%0b exp=0", busIf.in_ready); end
        pulseRestart();
        sendByte(8'h21);
        checks++; if (busIf.err !== 1'b1) begin failures++; $display("[TB] FAIL ic_33_err got=%0b exp=1", busIf.err); end
        checks++; if (busIf.core_rst !== 1'b1) begin failures++; $display("[TB] FAIL ic_33_core_rst got=%0b exp=1", busIf.core_rst); end
        idleCycles(1);
        checks++; if (wrTotal - base !== 0) begin failures++; $display("[TB] FAIL ic_no_write got=%0d exp=0", wrTotal - base); end
        pulseRestart();
    endtask

    task automatic test_stall_restart();
        int base;
        int k;
        base = wrTotal;
        sendByte(8'h03);
        idleCycles($urandom_range(0, 3));
        sendByte(8'h01);
        idleCycles($urandom_range(1, 4));
        sendByte(8'h02);
        idleCycles($urandom_range(1, 4));
        sendByte(8'h03);
        idleCycles($urandom_range(1, 4));
        checks++; if (wrTotal - base !== 1) begin failures++; $display("[TB] FAIL sr_first_write got=%0d exp=1", wrTotal - base); end
        busIf.in_valid = 1'b1;
        busIf.in_data  = 8'h04;
        restart        = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        restart        = 1'b0;
        checks++; if (busIf.ld_we !== 1'b0) begin failures++; $display("[TB] FAIL sr_dropped_strobe got=%0b exp=0", busIf.ld_we); end
        idleCycles(2);
        checks++; if (wrTotal - base !== 1) begin failures++; $display("[TB] FAIL sr_write_count got=%0d exp=1", wrTotal - base); end
        checks++; if (wrAddr[base[6:0]] !== 5'd0 || wrData[base[6:0]] !== 16'h0102) begin failures++; $display("[TB] FAIL sr_word0 got=%0d:%h exp=0:0102", wrAddr[base[6:0]], wrData[base[6:0]]); end
        checks++; if (busIf.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL sr_in_ready got=%0b exp=1", busIf.in_ready); end
        checks++; if (busIf.done !== 1'b0 || busIf.err !== 1'b0) begin failures++; $display("[TB] FAIL sr_flags got=%0b%0b exp=00", busIf.done, busIf.err); end
        sendByte(8'h01);
        idleCycles($urandom_range(0, 3));
        sendByte(8'hBE);
        sendByte(8'hEF);
        idleCycles($urandom_range(0, 3));
        sendByte(8'h51);
        k = base + 1;
        checks++; if (wrTotal - base !== 2) begin failures++; $display("[TB] FAIL sr_fresh_count got=%0d exp=2", wrTotal - base); end
        checks++; if (wrAddr[k[6:0]] !== 5'd0 || wrData[k[6:0]] !== 16'hBEEF) begin failures++; $display("[TB] FAIL sr_fresh_word got=%0d:%h exp=0:beef", wrAddr[k[6:0]], wrData[k[6:0]]); end
        checks++; if (busIf.done !== 1'b1) begin failures++; $display("[TB] FAIL sr_fresh_done got=%0b exp=1", busIf.done); end
        pulseRestart();
    endtask

    task automatic test_async_reset();
        int base;
        int k;
        sendByte(8'h02);
        sendByte(8'h77);
        #2;
        procRst = 1'b1;
        #1;
        checks++; if (busIf.ld_data !== 16'h0000) begin failures++; $display("[TB] FAIL ar_ld_data got=%h exp=0000", busIf.ld_data); end
        checks++; if (busIf.core_rst !== 1'b1 || busIf.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ar_core_rst_ready got=%0b%0b exp=11", busIf.core_rst, busIf.in_ready); end
        @(posedge clk);
        #1;
        procRst = 1'b0;
        base = wrTotal;
        sendByte(8'h02);
        sendByte(8'hCA);
        sendByte(8'hFE);
        #1;
        procRst = 1'b1;
        #1;
        checks++; if (busIf.ld_we !== 1'b0) begin failures++; $display("[TB] FAIL ar_inflight_we got=%0b exp=0", busIf.ld_we); end
        checks++; if (busIf.ld_data !== 16'h0000 || busIf.ld_addr !== 5'd0) begin failures++; $display("[TB] FAIL ar_inflight_bus got=%0d:%h exp=0:0000", busIf.ld_addr, busIf.ld_data); end
        @(posedge clk);
        #1;
        procRst = 1'b0;
        sendByte(8'h02);
        sendByte(8'hCA);
        sendByte(8'hFE);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h12);
        checks++; if (wrTotal - base !== 2) begin failures++; $display("[TB] FAIL ar_write_count got=%0d exp=2", wrTotal - base); end
        checks++; if (wrAddr[base[6:0]] !== 5'd0 || wrData[base[6:0]] !== 16'hCAFE) begin failures++; $display("[TB] FAIL ar_word0 got=%0d:%h exp=0:cafe", wrAddr[base[6:0]], wrData[base[6:0]]); end
        k = base + 1;
        checks++; if (wrAddr[k[6:0]] !== 5'd1 || wrData[k[6:0]] !== 16'h1234) begin failures++; $display("[TB] FAIL ar_word1 got=%0d:%h exp=1:1234", wrAddr[k[6:0]], wrData[k[6:0]]); end
        checks++; if (busIf.done !== 1'b1 || busIf.core_rst !== 1'b0) begin failures++; $display("[TB] FAIL ar_done got=%0b core_rst=%0b exp=1,0", busIf.done, busIf.core_rst); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_bad_checksum();
        test_illegal_count();
        test_stall_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
